// File: rtl/uart_arb_pkg.sv
// ----------------------------------------------------------------------------
// uart_arb_pkg
//   Shared definitions for the UART transmit arbiter (uart_tx_arb) and its
//   round-robin picker (rr_pick).
//
//   Contents:
//     NREQ_MAX       largest supported requester count
//     PTR_W          width of a requester index / round-robin pointer
//     state_e        arbiter FSM state encoding (3-bit)
//     onehot_to_idx  one-hot grant vector -> binary requester index
// ----------------------------------------------------------------------------
package uart_arb_pkg;

    localparam int NREQ_MAX = 8;
    localparam int PTR_W    = 3;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,  // post-reset hold-off while a stray UART frame drains
        ST_IDLE  = 3'd1,  // arbitrate among all requesters
        ST_ISSUE = 3'd2,  // txreq strobe cycle
        ST_WAIT  = 3'd3,  // waiting for the UART's txack pulse
        ST_DONE  = 3'd4,  // ack pulse to the client
        ST_LOCK  = 3'd5   // packet lock: only the current owner may issue
    } state_e;

    // Binary index of the (single) set bit; 0 when none is set.
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NREQ_MAX-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ_MAX; i++) begin
            if (oh[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. The winner is the first eligible index
//   strictly after the pointer, wrapping from N-1 back to 0. When the pointer
//   itself is the only eligible index it wins after a full rotation.
//
//   Parameters:
//     N        number of requesters (2..NREQ_MAX)
//   Ports:
//     i_elig   in   N       eligible requester mask
//     i_ptr    in   PTR_W   index of the most recent winner
//     o_win    out  N       one-hot winner, 0 when nothing is eligible
//     o_valid  out  1       a winner exists
// ----------------------------------------------------------------------------
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     i_elig,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_win,
    output logic             o_valid
);

    always_comb begin
        // NOTE: every output gets a default before any conditional write, so
        // no path leaves a value unassigned and no latch is inferred.
        o_win   = '0;
        o_valid = 1'b0;
        // Scan offsets 1..N from the pointer; the first eligible hit wins.
        for (int off = 1; off <= N; off++) begin
            for (int i = 0; i < N; i++) begin
                if (!o_valid && i_elig[i] && (i == ((int'(i_ptr) + off) % N))) begin
                    o_win[i] = 1'b1;
                    o_valid  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// ----------------------------------------------------------------------------
// uart_tx_arb
//   Shares one UART transmitter byte port among NREQ byte-stream clients.
//   Each byte is issued as a 1-cycle txreq, then the arbiter waits for the
//   UART's 1-cycle txack and returns a 1-cycle ack to the owning client.
//   Arbitration is round-robin per byte; with packet locking compiled in the
//   grant is held across bytes until a byte flagged last=1 is acknowledged.
//
//   Build option:
//     UART_ARB_PKTLOCK_EN  defined   -> packet locking (LOCK state reachable)
//                          undefined -> per-byte arbitration, last ignored
//
//   Parameters:
//     NREQ       number of requesters, 2..8
//     BOOT_WAIT  cycles held off after reset release (>= one UART frame)
//
//   Ports:
//     clk     in   1        system clock
//     rstn    in   1        synchronous active-low reset
//     req     in   NREQ     per-client request level; data/last valid while high
//     data    in   8*NREQ   client bytes, client i at [8*i+7:8*i]
//     last    in   NREQ     byte ends a packet (packet-lock build only)
//     ack     out  NREQ     1-cycle pulse: client's byte fully transmitted
//     gnt     out  NREQ     one-hot current owner, 0 when none
//     txreq   out  1        to UART: 1-cycle start strobe
//     txdata  out  8        to UART: byte, valid with txreq
//     txack   in   1        from UART: 1-cycle done pulse
// ----------------------------------------------------------------------------
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int BOOT_WAIT = 104166
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data,
    input  logic [NREQ-1:0]   last,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   gnt,
    output logic              txreq,
    output logic [7:0]        txdata,
    input  logic              txack
);

    localparam int                 CNT_W    = (BOOT_WAIT > 1) ? $clog2(BOOT_WAIT) : 1;
    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(BOOT_WAIT - 1);
    localparam logic [PTR_W-1:0]   PTR_INIT = PTR_W'(NREQ - 1);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] r_ptr;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_ack;
    logic             r_txreq;
    logic [7:0]       r_txdata;
`ifdef UART_ARB_PKTLOCK_EN
    logic             r_last;     // last flag of the byte currently in flight
`endif

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_win;
    logic            w_valid;
    logic [7:0]      w_sel_data;

    // While locked only the current owner may issue; elsewhere everyone may.
    assign w_elig = (r_state == ST_LOCK) ? (req & r_gnt) : req;

    rr_pick #(
        .N       (NREQ)
    ) u_rr_pick (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_win   (w_win),
        .o_valid (w_valid)
    );

    // One-hot mux of the winner's byte.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win[i]) w_sel_data = data[8*i +: 8];
        end
    end

`ifdef UART_ARB_PKTLOCK_EN
    logic w_sel_last;
    assign w_sel_last = |(last & w_win);
`else
    // Packet boundaries have no effect in the per-byte build.
    logic w_unused_last;
    assign w_unused_last = ^last;
`endif

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= ST_INIT;
            r_cnt    <= CNT_INIT;
            r_ptr    <= PTR_INIT;
            r_gnt    <= '0;
            r_ack    <= '0;
            r_txreq  <= 1'b0;
            r_txdata <= 8'h00;
`ifdef UART_ARB_PKTLOCK_EN
            r_last   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments here, so every branch reads the
            // pre-edge register values and the order of statements is moot.
            // txreq and ack are strobes: low unless a branch raises them.
            r_txreq <= 1'b0;
            r_ack   <= '0;

            case (r_state)
                // The UART has no reset: a frame started before rstn fell
                // must finish before anything new is issued.
                ST_INIT: begin
                    if (r_cnt == '0) r_state <= ST_IDLE;
                    else             r_cnt   <= r_cnt - CNT_W'(1);
                end

                ST_IDLE, ST_LOCK: begin
                    if (w_valid) begin
                        r_state  <= ST_ISSUE;
                        r_gnt    <= w_win;
                        r_txdata <= w_sel_data;
                        r_txreq  <= 1'b1;
                        r_ptr    <= onehot_to_idx(NREQ_MAX'(w_win));
`ifdef UART_ARB_PKTLOCK_EN
                        r_last   <= w_sel_last;
`endif
                    end
                end

                // txreq was raised on entry and drops here: exactly 1 cycle.
                ST_ISSUE: r_state <= ST_WAIT;

                // Request changes are ignored; only txack moves us on.
                ST_WAIT: begin
                    if (txack) begin
                        r_ack   <= r_gnt;
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
`ifdef UART_ARB_PKTLOCK_EN
                    if (!r_last) begin
                        r_state <= ST_LOCK;           // keep the grant
                    end else begin
                        r_gnt   <= '0;
                        r_state <= ST_IDLE;
                    end
`else
                    r_gnt   <= '0;
                    r_state <= ST_IDLE;
`endif
                end

                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign ack    = r_ack;
    assign gnt    = r_gnt;
    assign txreq  = r_txreq;
    assign txdata = r_txdata;

endmodule

// File: tb/tb_uart_tx_arb.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arb
//   Directed bench for uart_tx_arb (NREQ=4, BOOT_WAIT=16) with a UART model
//   that answers each txreq with a txack pulse 20 cycles later. Works in
//   both the per-byte and the UART_ARB_PKTLOCK_EN build.
// ----------------------------------------------------------------------------
module tb_uart_tx_arb;

    localparam int NREQ      = 4;
    localparam int BOOT_WAIT = 16;
    localparam int FRAME     = 20;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   last;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   gnt;
    logic              txreq;
    logic [7:0]        txdata;
    logic              txack;
    logic              txack_m    = 1'b0;
    logic              txack_spur = 1'b0;

    assign txack = txack_m | txack_spur;

    uart_tx_arb #(
        .NREQ      (NREQ),
        .BOOT_WAIT (BOOT_WAIT)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .req    (req),
        .data   (data),
        .last   (last),
        .ack    (ack),
        .gnt    (gnt),
        .txreq  (txreq),
        .txdata (txdata),
        .txack  (txack)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Cycle counter, UART model and protocol monitor
    // ------------------------------------------------------------------
    int   cyc         = 0;
    int   busy        = 0;
    int   n_txreq     = 0;
    int   n_ack       = 0;
    int   width_err   = 0;
    int   overlap_err = 0;
    int   txack_cyc   = -1;
    logic prev_txreq  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        txack_m <= (busy == 1);
        if (busy == 1) txack_cyc <= cyc;
        if (txreq === 1'b1) begin
            n_txreq <= n_txreq + 1;
            if (prev_txreq === 1'b1) width_err <= width_err + 1;
            if (busy > 1) overlap_err <= overlap_err + 1;
            busy <= FRAME;
        end else if (busy > 0) begin
            busy <= busy - 1;
        end
        prev_txreq <= txreq;
        if (ack != '0) n_ack <= n_ack + 1;
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_txreq(input string name, output int c);
        c = -1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (txreq === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) check({name, "_txreq_timeout"}, 0, 1);
    endtask

    task automatic wait_ack(input string name, output int c);
        c = -1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (ack != '0) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) check({name, "_ack_timeout"}, 0, 1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus tables
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          exp_gnt;
        int          exp_txdata;
    } vec_t;

    vec_t vecs [5];

`ifdef UART_ARB_PKTLOCK_EN
    localparam int T3_N = 4;
    int t3_idx [5] = '{1, 1, 1, 3, 0};
    int t3_dat [5] = '{'h10, 'h11, 'h12, 'h30, 'h00};
`else
    localparam int T3_N = 5;
    int t3_idx [5] = '{1, 3, 1, 3, 1};
    int t3_dat [5] = '{'h10, 'h30, 'h11, 'h31, 'h12};
`endif

    int t2_idx [5] = '{0, 1, 2, 3, 0};
    int t2_dat [5] = '{'hC0, 'hC1, 'hC2, 'hC3, 'hC1};

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int c, ca, rel, prev_txack, n0, c1, c3;

        // Pointer evolves 2 -> 3 -> 1 -> 0 -> 0 -> 3 across these entries.
        vecs[0] = '{req: 4'b1111, data: 32'h44332211, exp_gnt: 'h8, exp_txdata: 'h44};
        vecs[1] = '{req: 4'b0110, data: 32'hDEC3B2A1, exp_gnt: 'h2, exp_txdata: 'hB2};
        vecs[2] = '{req: 4'b0011, data: 32'h0000F00F, exp_gnt: 'h1, exp_txdata: 'h0F};
        vecs[3] = '{req: 4'b0001, data: 32'h12345678, exp_gnt: 'h1, exp_txdata: 'h78};
        vecs[4] = '{req: 4'b1000, data: 32'h9A000000, exp_gnt: 'h8, exp_txdata: 'h9A};

        // ---- 1: reset state and boot hold-off ----
        rstn = 1'b0;
        req  = 4'b0100;
        data = 32'h00A50000;
        last = 4'b1111;
        repeat (3) tick();
        check("rst_txreq",  int'(txreq),  0);
        check("rst_txdata", int'(txdata), 0);
        check("rst_ack",    int'(ack),    0);
        check("rst_gnt",    int'(gnt),    0);
        rstn = 1'b1;
        rel  = cyc;
        wait_txreq("boot", c);
        check("boot_txreq_cycle", c - rel, BOOT_WAIT + 1);
        check("boot_gnt",    int'(gnt),    'h4);
        check("boot_txdata", int'(txdata), 'hA5);
        wait_ack("boot", ca);
        check("boot_ack",         int'(ack),       'h4);
        check("boot_ack_latency", ca - txack_cyc, 1);
        req = '0;
        tick();
        tick();

        // ---- table: arbitration under several request patterns ----
        for (int k = 0; k < 5; k++) begin
            req  = vecs[k].req;
            data = vecs[k].data;
            wait_txreq($sformatf("vec%0d", k), c);
            check($sformatf("vec%0d_gnt", k),    int'(gnt),    vecs[k].exp_gnt);
            check($sformatf("vec%0d_txdata", k), int'(txdata), vecs[k].exp_txdata);
            wait_ack($sformatf("vec%0d", k), ca);
            check($sformatf("vec%0d_ack", k),    int'(ack),    vecs[k].exp_gnt);
            req = '0;
            tick();
            tick();
        end

        // ---- 2: all four held, re-armed at each ack ----
        for (int i = 0; i < NREQ; i++) data[8*i +: 8] = 8'(8'hC0 + i);
        req = 4'b1111;
        prev_txack = -1;
        for (int k = 0; k < 5; k++) begin
            wait_txreq($sformatf("rr%0d", k), c);
            if (k > 0) check($sformatf("rr%0d_b2b_latency", k), c - prev_txack, 3);
            check($sformatf("rr%0d_gnt", k),    int'(gnt),    1 << t2_idx[k]);
            check($sformatf("rr%0d_txdata", k), int'(txdata), t2_dat[k]);
            wait_ack($sformatf("rr%0d", k), ca);
            prev_txack = txack_cyc;
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) data[8*i +: 8] = 8'(data[8*i +: 8] + 8'd1);
            end
            if (k == 4) req = '0;
        end
        check("rr_txreq_width_errs",   width_err,   0);
        check("rr_txreq_overlap_errs", overlap_err, 0);
        tick();
        tick();

        // ---- 3: 3-byte packet from client 1 against client 3 ----
        data = '0;
        last = 4'b1111;
        data[15:8]  = 8'h10;
        last[1]     = 1'b0;
        data[31:24] = 8'h30;
        c1 = 0;
        c3 = 0;
        req = 4'b1010;
        for (int k = 0; k < T3_N; k++) begin
            wait_txreq($sformatf("pkt%0d", k), c);
            check($sformatf("pkt%0d_gnt", k),    int'(gnt),    1 << t3_idx[k]);
            check($sformatf("pkt%0d_txdata", k), int'(txdata), t3_dat[k]);
            wait_ack($sformatf("pkt%0d", k), ca);
            if (ack[1]) begin
                c1++;
                if (c1 == 3) begin
                    req[1] = 1'b0;
                end else begin
                    data[15:8] = 8'(8'h10 + c1);
                    last[1]    = (c1 == 2);
                end
            end
            if (ack[3]) begin
                c3++;
                data[31:24] = 8'(8'h30 + c3);
            end
            if (k == T3_N - 1) req = '0;
        end
        last = 4'b1111;
        repeat (3) tick();

        // ---- 4: req held past the ack edge with stale data ----
        req = 4'b0001;
        data[7:0] = 8'h5A;
        wait_txreq("stale", c);
        check("stale_txdata", int'(txdata), 'h5A);
        wait_ack("stale", ca);
        check("stale_ack", int'(ack), 'h1);
        n0 = n_txreq;
        tick();
        req = '0;
        repeat (30) tick();
        check("stale_no_duplicate", n_txreq - n0, 0);

        // ---- 6: spurious txack while idle ----
        check("spur_pre_gnt", int'(gnt), 0);
        n0 = n_ack;
        txack_spur = 1'b1;
        tick();
        txack_spur = 1'b0;
        rel = cyc;
        req = 4'b0100;
        data[23:16] = 8'h3C;
        wait_txreq("spur", c);
        check("spur_no_ack",         n_ack - n0, 0);
        check("spur_issue_latency",  c - rel, 1);
        check("spur_gnt",            int'(gnt),    'h4);
        check("spur_txdata",         int'(txdata), 'h3C);
        wait_ack("spur", ca);
        check("spur_ack",            int'(ack),    'h4);
        req = '0;
        tick();
        tick();

        // ---- 5: reset pulse during WAIT ----
        req = 4'b1000;
        data[31:24] = 8'h77;
        wait_txreq("rstw", c);
        check("rstw_gnt", int'(gnt), 'h8);
        repeat (5) tick();
        rstn = 1'b0;
        tick();
        tick();
        check("rstw_txreq",  int'(txreq),  0);
        check("rstw_txdata", int'(txdata), 0);
        check("rstw_ack",    int'(ack),    0);
        check("rstw_gnt",    int'(gnt),    0);
        rstn = 1'b1;
        rel  = cyc;
        n0   = n_ack;
        wait_txreq("rstw_retry", c);
        check("rstw_retry_cycle", c - rel, BOOT_WAIT + 1);
        check("rstw_lost_ack",    n_ack - n0, 0);
        check("rstw_retry_gnt",    int'(gnt),    'h8);
        check("rstw_retry_txdata", int'(txdata), 'h77);
        wait_ack("rstw_retry", ca);
        check("rstw_retry_ack", int'(ack), 'h8);
        req = '0;
        repeat (3) tick();

        check("final_txreq_width_errs",   width_err,   0);
        check("final_txreq_overlap_errs", overlap_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
